// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants and FSM state type
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int LOCK_SETTLE = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } vga_state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the generator to its consumers
interface vga_timing_gen_if;

    logic        hsync;
    logic        vsync;
    logic        display_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        line_start;
    logic        frame_start;
    logic        running;
    logic [15:0] frame_count;

    modport master (
        output hsync, vsync, display_en, x, y,
        output line_start, frame_start, running, frame_count
    );

    modport slave (
        input hsync, vsync, display_en, x, y,
        input line_start, frame_start, running, frame_count
    );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with active/sync decode
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    // One extra bit so a sync window ending exactly at TOTAL still compares correctly
    localparam logic [W:0] LAST       = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_END    = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEGIN = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);

    logic [W:0] count_x;

    assign count_x = {1'b0, count};
    assign wrap    = en && (count_x == LAST);
    assign active  = count_x < ACT_END;
    assign sync    = (count_x >= SYNC_BEGIN) && (count_x < SYNC_END);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - lock-gated VGA raster timing generator; `VGA_FRAME_COUNTER_EN adds frame_count
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP        = vga_timing_pkg::H_FP,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP        = vga_timing_pkg::V_FP,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int LOCK_SETTLE = vga_timing_pkg::LOCK_SETTLE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    vga_timing_gen_if.master  vga
);

    localparam int H_PERIOD = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_PERIOD = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_PERIOD);
    localparam int VW       = $clog2(V_PERIOD);
    localparam int SW       = $clog2(LOCK_SETTLE + 1);

    logic          lock_meta;
    logic          lock_s;
    vga_state_t    state;
    logic [SW-1:0] settle_cnt;
    logic          running_q;
    logic          in_run;

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    logic          unused_v_wrap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // settle_cnt holds the number of consecutive locked samples already seen
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            running_q  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        if (LOCK_SETTLE <= 1) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= SW'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SW'(LOCK_SETTLE - 1)) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                        running_q  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    settle_cnt <= '0;
                    running_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_run = (state == RUN);

    // Counters are cleared whenever idle so every restart begins at (0,0)
    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_counter (
        .clock  (clock),
        .reset  (reset),
        .en     (in_run),
        .clear  (!in_run),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_counter (
        .clock  (clock),
        .reset  (reset),
        .en     (h_wrap),
        .clear  (!in_run),
        .count  (v_count),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    assign unused_v_wrap = v_wrap;

    logic visible;
    logic at_line_start;
    logic at_frame_start;

    assign visible        = in_run && h_active && v_active;
    assign at_line_start  = in_run && (h_count == '0);
    assign at_frame_start = at_line_start && (v_count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga.hsync       <= ~HSYNC_POL;
            vga.vsync       <= ~VSYNC_POL;
            vga.display_en  <= 1'b0;
            vga.x           <= '0;
            vga.y           <= '0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.hsync       <= (in_run && h_sync) ? HSYNC_POL : ~HSYNC_POL;
            vga.vsync       <= (in_run && v_sync) ? VSYNC_POL : ~VSYNC_POL;
            vga.display_en  <= visible;
            vga.x           <= visible ? 10'(h_count) : 10'd0;
            vga.y           <= visible ? 10'(v_count) : 10'd0;
            vga.line_start  <= at_line_start;
            vga.frame_start <= at_frame_start;
        end
    end

    assign vga.running = running_q;

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_cnt;

    // Steps together with the frame_start register so both are visible on the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= 16'h0;
        end else if (at_frame_start) begin
            frame_cnt <= frame_cnt + 16'h1;
        end
    end

    assign vga.frame_count = frame_cnt;
`else
    assign vga.frame_count = 16'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench: raster model from cycle index, random lock patterns
module tb_vga_timing_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int SETTLE_N = 16;
    localparam int FT = HT * VT;
`ifdef VGA_FRAME_COUNTER_EN
    localparam int FC_AFTER_TWO = 2;
`else
    localparam int FC_AFTER_TWO = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pll_locked = 1'b1;
    bit   chk_en = 1'b0;

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .LOCK_SETTLE (SETTLE_N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .vga        (vga)
    );

    always #20 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [41:0] pack(input logic hs, input logic vs, input logic de,
                                         input logic [9:0] xx, input logic [9:0] yy,
                                         input logic ls, input logic fs, input logic rn,
                                         input logic [15:0] fc);
        return {hs, vs, de, xx, yy, ls, fs, rn, fc};
    endfunction

    // Model: running after edge e iff the last 16 lock samples taken two edges earlier were all 1;
    // the raster position is simply the number of running edges before this one.
    int          streak = 0;
    int          streak_d1 = 0;
    int          run_len = 0;
    bit          m_run = 1'b0;
    logic [15:0] m_fc = 16'h0;
    logic [41:0] exp_v = 42'h0;

    initial exp_v = pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 16'h0);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            streak    = 0;
            streak_d1 = 0;
            run_len   = 0;
            m_run     = 1'b0;
            m_fc      = 16'h0;
            exp_v     = pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        end else begin
            int lock_age, n, h, v;
            bit run_now, de, hs, vs, ls, fs;
            lock_age  = streak_d1;
            streak_d1 = streak;
            streak    = pll_locked ? streak + 1 : 0;
            run_now   = (lock_age >= SETTLE_N);
            de = 0; hs = 0; vs = 0; ls = 0; fs = 0; h = 0; v = 0;
            if (m_run) begin
                n  = run_len - 1;
                h  = n % HT;
                v  = (n / HT) % VT;
                de = (h < HA) && (v < VA);
                hs = (h >= HA + HF) && (h < HA + HF + HS);
                vs = (v >= VA + VF) && (v < VA + VF + VS);
                ls = (h == 0);
                fs = (h == 0) && (v == 0);
            end
`ifdef VGA_FRAME_COUNTER_EN
            if (fs) m_fc = m_fc + 16'h1;
`endif
            exp_v = pack(!hs, !vs, de, de ? 10'(h) : 10'd0, de ? 10'(v) : 10'd0,
                         ls, fs, run_now, m_fc);
            run_len = run_now ? run_len + 1 : 0;
            m_run   = run_now;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic [41:0] act;
            act = pack(vga.hsync, vga.vsync, vga.display_en, vga.x, vga.y,
                       vga.line_start, vga.frame_start, vga.running, vga.frame_count);
            n_checks++;
            if (act === exp_v) n_pass++;
            else $display("FAIL raster cyc=%0d got %h expected %h", cyc, act, exp_v);
        end
    end

    initial begin
        int k, c0, i, hs_first, hs_cnt, de_cnt, x_bad, vs_first, vs_cnt, y_max;
        reset = 1'b1;
        pll_locked = 1'b1;
        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        check("reset_hsync", int'(vga.hsync), 1);
        check("reset_vsync", int'(vga.vsync), 1);
        check("reset_running", int'(vga.running), 0);

        reset = 1'b0;
        c0 = cyc;
        k = 0;
        while (!vga.running && k < 100) begin @(negedge clock); k++; end
        check("run_rise_latency", cyc - c0, 2 + SETTLE_N);
        check("pre_start_hsync", int'(vga.hsync), 1);
        @(negedge clock);
        check("first_frame_start", int'(vga.frame_start), 1);
        check("first_line_start", int'(vga.line_start), 1);

        hs_first = -1; hs_cnt = 0; de_cnt = 0; x_bad = 0;
        for (int j = 0; j < HT; j++) begin
            if (!vga.hsync) begin hs_cnt++; if (hs_first < 0) hs_first = j; end
            if (vga.display_en) begin de_cnt++; if (int'(vga.x) != j) x_bad++; end
            @(negedge clock);
        end
        check("hsync_offset", hs_first, 656);
        check("hsync_width", hs_cnt, 96);
        check("line_display_cnt", de_cnt, 640);
        check("line_x_errors", x_bad, 0);
        check("second_line_start", int'(vga.line_start), 1);

        i = HT; vs_first = -1; vs_cnt = 0; y_max = 0;
        while (!vga.frame_start && i < 2 * FT) begin
            if (!vga.vsync) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
            if (vga.display_en) begin de_cnt++; if (int'(vga.y) > y_max) y_max = int'(vga.y); end
            @(negedge clock);
            i++;
        end
        check("frame_period", i, 10400);
        check("vsync_offset", vs_first, 6400);
        check("vsync_width", vs_cnt, 1600);
        check("frame_display_cnt", de_cnt, 3840);
        check("last_visible_y", y_max, 5);
        check("frame_count_two", int'(vga.frame_count), FC_AFTER_TWO);

        repeat ($urandom_range(5000, 100)) @(negedge clock);
        pll_locked = 1'b0;
        k = 0;
        while (vga.running && k < 10) begin @(negedge clock); k++; end
        check("drop_to_idle", k, 3);
        @(negedge clock);
        check("drop_hsync_idle", int'(vga.hsync), 1);
        check("drop_vsync_idle", int'(vga.vsync), 1);
        check("drop_display_idle", int'(vga.display_en), 0);

        repeat ($urandom_range(30, 1)) @(negedge clock);
        pll_locked = 1'b1;
        k = 0;
        while (!vga.frame_start && k < 100) begin @(negedge clock); k++; end
        check("relock_latency", k, 2 + SETTLE_N + 1);
        check("relock_y", int'(vga.y), 0);
        check("relock_x", int'(vga.x), 0);

        repeat (200) @(negedge clock);
        pll_locked = 1'b0;
        repeat (5) @(negedge clock);
        pll_locked = 1'b1;
        repeat (8) @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        pll_locked = 1'b1;
        k = 0;
        while (!vga.running && k < 100) begin @(negedge clock); k++; end
        check("glitch_restart", k, 2 + SETTLE_N);

        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(2500, 20)) @(negedge clock);
            pll_locked = 1'b0;
            if ($urandom_range(2, 0) == 0) repeat (1) @(negedge clock);
            else repeat ($urandom_range(40, 1)) @(negedge clock);
            pll_locked = 1'b1;
        end
        repeat (300) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
